order_scheduler: RTL and testbench
==================================

# order_scheduler

Sequences trade intents from the market-making signal logic onto the single downstream order-gateway port. It latches buy/sell requests with their quote prices, arbitrates between sides and enforces a token-bucket rate limit, a signed net-position limit and an inter-order cooldown. It emits one order at a time over a valid/ready handshake. It sits between the strategy core (`buy_order`/`sell_order`, bid/ask) and the gateway serializer.

## Interface
- `PRICE_W`, 8: price width
- `TOKEN_MAX`, 4: bucket capacity; also the reset token count
- `REFILL_CYCLES`, 16: cycles per token refill, ≥1
- `POS_LIMIT`, 8: allowed net position range is −POS_LIMIT..+POS_LIMIT
- `COOLDOWN_CYCLES`, 2: idle cycles after each accepted order, ≥0
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `kill` in 1: clears pending requests, blocks new grants while high
- `buy_req` in 1: buy intent, sampled every cycle
- `sell_req` in 1: sell intent, sampled every cycle
- `bid_price` in PRICE_W: price attached to buy requests
- `ask_price` in PRICE_W: price attached to sell requests
- `ord_valid` out 1: order offered to gateway
- `ord_ready` in 1: gateway accepts
- `ord_side` out 1: 0 = buy, 1 = sell
- `ord_price` out PRICE_W: order price
- `position` out POS_W: signed net position, POS_W = $clog2(POS_LIMIT+1)+1
- `tokens` out $clog2(TOKEN_MAX+1): current bucket level
- `reject` out 1: one-cycle pulse when a pending request is dropped by the position limit

## Operation
- **Capture:**
  - `buy_req` high sets `pend_buy` and latches `bid_price`; `sell_req` does the same with `ask_price` into separate per-side registers.
  - A request while its side is already pending overwrites the price (latest wins). Pending is 1-deep per side.
- **FSM states:** IDLE, ISSUE, COOLDOWN.
- **IDLE:**
  - Buy is eligible if `pend_buy`, `tokens>0`, `position+1 ≤ POS_LIMIT` and `!kill`.
  - Sell is eligible if `pend_sell`, `tokens>0`, `position−1 ≥ −POS_LIMIT` and `!kill`.
  - If one side is eligible, grant it. If both are, grant the side opposite `last_side`; `last_side` resets to sell, so buy wins the first tie.
  - On grant: load `ord_side`/`ord_price` from that side's latch, clear that side's pending, then go to ISSUE.
- **Position-blocked pending:** cleared with a `reject` pulse that cycle.
- **Token-blocked pending:** held until a token is available.
- **ISSUE:**
  - `ord_valid=1`; side and price stay stable until `ord_valid && ord_ready`.
  - On handshake: `position ± 1`, token decrement, `last_side` update, then go to COOLDOWN, or straight to IDLE if COOLDOWN_CYCLES=0.
  - `kill` does not abort ISSUE; the handshake completes.
- **COOLDOWN:** `ord_valid=0` for exactly COOLDOWN_CYCLES cycles, then IDLE. Captures continue.
- **Token bucket:**
  - Refill counter wraps every REFILL_CYCLES cycles and adds 1 token, saturating at TOKEN_MAX.
  - Refill and consume on the same cycle leave `tokens` unchanged.
- **Simultaneous events:**
  - `kill` and a request on the same cycle: `kill` wins, nothing is left pending.
  - A request on the same cycle its side is granted: the new request stays pending with the new price.

## Timing
- Reset values:
  - Outputs: `ord_valid=0`, `ord_side=0`, `ord_price=0`, `position=0`, `tokens=TOKEN_MAX`, `reject=0`.
  - Internal: pendings cleared, refill counter=0, `last_side`=sell, state IDLE.
- Reset mid-ISSUE drops the offered order immediately; no handshake is implied.
- Latency, unblocked: request high in cycle N → `ord_valid` high from cycle N+2.
- The gateway must not assume `ord_valid` drops after acceptance unless COOLDOWN_CYCLES>0.
- `reject` goes high the cycle after the blocking condition is seen in IDLE.
- All outputs are registered.

## Structure
- Shared `order_sched_pkg`: `state_t` enum {IDLE, ISSUE, COOLDOWN}, `side_t` enum {SIDE_BUY=0, SIDE_SELL=1}.
- Sub-module `token_bucket`:
  - Parameters: TOKEN_MAX, REFILL_CYCLES.
  - Ports: `clk`, `reset`, `consume`, `tokens`, `avail`.
- Expected RTL size: ~200 lines total.

## Test plan
- **Basic buy:** reset, `buy_req` 1 cycle with bid=0x70, `ord_ready=1` → `ord_valid` from N+2 for 1 cycle, side=0, price=0x70, then position=1, tokens=3.
- **Tie arbitration:** `buy_req` and `sell_req` together, bid=0x70, ask=0x90, `ord_ready=1` → buy issued first, sell after 2 cooldown cycles, then position=0, tokens=2.
- **Rate limit:** 6 buys back-to-back with ready=1 and POS_LIMIT=8 → 4 orders issue; the 5th waits for a refill 16 cycles after the previous refill point; tokens never exceeds 4.
- **Position limit:** POS_LIMIT=2, three separated buys → 2 orders, then a `reject` pulse; a following sell issues and position=1.
- **Backpressure:** `ord_ready=0` for 10 cycles during ISSUE with `bid_price` changing every cycle → `ord_price` stays at the granted value until handshake; the next order carries the latest bid.
- **Kill and reset:** `kill` asserted during ISSUE → handshake still completes and the other pending side is cleared. `reset` asserted mid-ISSUE → `ord_valid=0` next cycle and all reset values restored.

Source files
------------

// File: rtl/order_sched_pkg.sv
// Shared types for the order scheduler: FSM states and order side encoding.
package order_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COOLDOWN
    } state_t;

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } side_t;

endpackage

// File: rtl/order_scheduler_token_bucket.sv
// Token bucket rate limiter: one token per REFILL_CYCLES, capped at TOKEN_MAX.
module token_bucket
    import order_sched_pkg::*;
#(
    parameter int TOKEN_MAX     = 4,
    parameter int REFILL_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             consume,
    output logic [$clog2(TOKEN_MAX+1)-1:0]   tokens,
    output logic                             avail
);

    localparam int TOK_W = $clog2(TOKEN_MAX + 1);
    localparam int RC_W  = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

    logic [RC_W-1:0]  refill_cnt_q, refill_cnt_d;
    logic [TOK_W-1:0] tokens_q, tokens_d;
    logic             refill;

    always_comb begin
        refill       = (refill_cnt_q == RC_W'(REFILL_CYCLES - 1));
        refill_cnt_d = refill ? '0 : refill_cnt_q + 1'b1;
        tokens_d     = tokens_q;
        // A refill landing on a consume cancels out.
        if (refill && !consume) begin
            if (tokens_q != TOK_W'(TOKEN_MAX)) begin
                tokens_d = tokens_q + 1'b1;
            end
        end else if (consume && !refill) begin
            if (tokens_q != '0) begin
                tokens_d = tokens_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refill_cnt_q <= '0;
            tokens_q     <= TOK_W'(TOKEN_MAX);
        end else begin
            refill_cnt_q <= refill_cnt_d;
            tokens_q     <= tokens_d;
        end
    end

    assign tokens = tokens_q;
    assign avail  = (tokens_q != '0);

endmodule

// File: rtl/order_scheduler.sv
// Arbitrates latched buy/sell intents onto one gateway port under rate,
// position and cooldown limits; one order in flight at a time.
module order_scheduler
    import order_sched_pkg::*;
#(
    parameter int PRICE_W         = 8,
    parameter int TOKEN_MAX       = 4,
    parameter int REFILL_CYCLES   = 16,
    parameter int POS_LIMIT       = 8,
    parameter int COOLDOWN_CYCLES = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 kill,
    input  logic                                 buy_req,
    input  logic                                 sell_req,
    input  logic [PRICE_W-1:0]                   bid_price,
    input  logic [PRICE_W-1:0]                   ask_price,
    output logic                                 ord_valid,
    input  logic                                 ord_ready,
    output logic                                 ord_side,
    output logic [PRICE_W-1:0]                   ord_price,
    output logic signed [$clog2(POS_LIMIT+1):0]  position,
    output logic [$clog2(TOKEN_MAX+1)-1:0]       tokens,
    output logic                                 reject
);

    localparam int POS_W = $clog2(POS_LIMIT + 1) + 1;
    localparam int CD_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    state_t                    state_q, state_d;
    logic                      pend_buy_q, pend_buy_d;
    logic                      pend_sell_q, pend_sell_d;
    logic [PRICE_W-1:0]        bid_lat_q, bid_lat_d;
    logic [PRICE_W-1:0]        ask_lat_q, ask_lat_d;
    side_t                     last_side_q, last_side_d;
    logic                      ord_valid_q, ord_valid_d;
    side_t                     ord_side_q, ord_side_d;
    logic [PRICE_W-1:0]        ord_price_q, ord_price_d;
    logic signed [POS_W-1:0]   position_q, position_d;
    logic                      reject_q, reject_d;
    logic [CD_W-1:0]           cd_cnt_q, cd_cnt_d;

    logic consume;
    logic tok_avail;
    logic buy_ok, sell_ok, buy_elig, sell_elig, grant_buy, grant_sell;
    int   pos_i;

    token_bucket #(
        .TOKEN_MAX     (TOKEN_MAX),
        .REFILL_CYCLES (REFILL_CYCLES)
    ) u_bucket (
        .clk     (clk),
        .reset   (reset),
        .consume (consume),
        .tokens  (tokens),
        .avail   (tok_avail)
    );

    always_comb begin
        state_d     = state_q;
        pend_buy_d  = pend_buy_q;
        pend_sell_d = pend_sell_q;
        bid_lat_d   = bid_lat_q;
        ask_lat_d   = ask_lat_q;
        last_side_d = last_side_q;
        ord_valid_d = ord_valid_q;
        ord_side_d  = ord_side_q;
        ord_price_d = ord_price_q;
        position_d  = position_q;
        reject_d    = 1'b0;
        cd_cnt_d    = cd_cnt_q;
        consume     = 1'b0;
        grant_buy   = 1'b0;
        grant_sell  = 1'b0;

        pos_i     = int'(position_q);
        buy_ok    = (pos_i + 1 <= POS_LIMIT);
        sell_ok   = (pos_i - 1 >= -POS_LIMIT);
        buy_elig  = pend_buy_q  && tok_avail && buy_ok  && !kill;
        sell_elig = pend_sell_q && tok_avail && sell_ok && !kill;

        case (state_q)
            IDLE: begin
                if (buy_elig && sell_elig) begin
                    grant_buy  = (last_side_q == SIDE_SELL);
                    grant_sell = (last_side_q == SIDE_BUY);
                end else begin
                    grant_buy  = buy_elig;
                    grant_sell = sell_elig;
                end
                if (grant_buy) begin
                    ord_side_d  = SIDE_BUY;
                    ord_price_d = bid_lat_q;
                    pend_buy_d  = 1'b0;
                end else if (grant_sell) begin
                    ord_side_d  = SIDE_SELL;
                    ord_price_d = ask_lat_q;
                    pend_sell_d = 1'b0;
                end
                if (grant_buy || grant_sell) begin
                    ord_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
                // Position-blocked intents are dropped rather than held.
                if (!kill && pend_buy_q && !buy_ok) begin
                    pend_buy_d = 1'b0;
                    reject_d   = 1'b1;
                end
                if (!kill && pend_sell_q && !sell_ok) begin
                    pend_sell_d = 1'b0;
                    reject_d    = 1'b1;
                end
            end
            ISSUE: begin
                if (ord_ready) begin
                    ord_valid_d = 1'b0;
                    consume     = 1'b1;
                    last_side_d = ord_side_q;
                    position_d  = (ord_side_q == SIDE_BUY) ? position_q + 1'b1
                                                           : position_q - 1'b1;
                    cd_cnt_d    = '0;
                    state_d     = (COOLDOWN_CYCLES > 0) ? COOLDOWN : IDLE;
                end
            end
            COOLDOWN: begin
                if (int'(cd_cnt_q) + 1 >= COOLDOWN_CYCLES) begin
                    state_d = IDLE;
                end else begin
                    cd_cnt_d = cd_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // New requests land after the grant so a same-cycle request survives it.
        if (buy_req) begin
            pend_buy_d = 1'b1;
            bid_lat_d  = bid_price;
        end
        if (sell_req) begin
            pend_sell_d = 1'b1;
            ask_lat_d   = ask_price;
        end
        if (kill) begin
            pend_buy_d  = 1'b0;
            pend_sell_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_buy_q  <= 1'b0;
            pend_sell_q <= 1'b0;
            bid_lat_q   <= '0;
            ask_lat_q   <= '0;
            last_side_q <= SIDE_SELL;
            ord_valid_q <= 1'b0;
            ord_side_q  <= SIDE_BUY;
            ord_price_q <= '0;
            position_q  <= '0;
            reject_q    <= 1'b0;
            cd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            pend_buy_q  <= pend_buy_d;
            pend_sell_q <= pend_sell_d;
            bid_lat_q   <= bid_lat_d;
            ask_lat_q   <= ask_lat_d;
            last_side_q <= last_side_d;
            ord_valid_q <= ord_valid_d;
            ord_side_q  <= ord_side_d;
            ord_price_q <= ord_price_d;
            position_q  <= position_d;
            reject_q    <= reject_d;
            cd_cnt_q    <= cd_cnt_d;
        end
    end

    assign ord_valid = ord_valid_q;
    assign ord_side  = ord_side_q;
    assign ord_price = ord_price_q;
    assign position  = position_q;
    assign reject    = reject_q;

endmodule

// File: tb/tb_order_scheduler.sv
// Scoreboard bench for order_scheduler with default parameters (POS_LIMIT=8).
module tb_order_scheduler;

    typedef struct packed {
        logic       side;
        logic [7:0] price;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              kill = 1'b0;
    logic              buy_req = 1'b0;
    logic              sell_req = 1'b0;
    logic [7:0]        bid_price = 8'h00;
    logic [7:0]        ask_price = 8'h00;
    logic              ord_ready = 1'b0;
    logic              ord_valid;
    logic              ord_side;
    logic [7:0]        ord_price;
    logic signed [4:0] position;
    logic [2:0]        tokens;
    logic              reject;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   base = 0;
    int   hs_count = 0;
    int   rej_seen = 0;
    int   rej_exp = 0;
    int   hs0 = 0;
    exp_t exp_q[$];
    int   hs_rel[$];
    int   rate_exp[6] = '{3, 7, 11, 15, 19, 34};

    order_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .kill      (kill),
        .buy_req   (buy_req),
        .sell_req  (sell_req),
        .bid_price (bid_price),
        .ask_price (ask_price),
        .ord_valid (ord_valid),
        .ord_ready (ord_ready),
        .ord_side  (ord_side),
        .ord_price (ord_price),
        .position  (position),
        .tokens    (tokens),
        .reject    (reject)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        kill      = 1'b0;
        buy_req   = 1'b0;
        sell_req  = 1'b0;
        ord_ready = 1'b0;
        bid_price = 8'h00;
        ask_price = 8'h00;
        tick(2);
        reset = 1'b0;
        base  = cyc;
    endtask

    task automatic expect_ord(input logic s, input logic [7:0] p);
        exp_t e;
        e.side  = s;
        e.price = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_hs(input int target);
        int k;
        k = 0;
        while (hs_count < target && k < 200) begin
            tick();
            k++;
        end
        chk("hs_count_reached", hs_count, target);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},    ord_valid, 0);
        chk({tag, "_side"},     ord_side, 0);
        chk({tag, "_price"},    ord_price, 0);
        chk({tag, "_position"}, position, 0);
        chk({tag, "_tokens"},   tokens, 4);
        chk({tag, "_reject"},   reject, 0);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    initial begin : monitor
        exp_t e;
        logic       prev_stall;
        logic       prev_side;
        logic [7:0] prev_price;
        prev_stall = 1'b0;
        prev_side  = 1'b0;
        prev_price = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                chk("tokens_over_max", int'(tokens > 3'd4), 0);
                if (prev_stall && ord_valid) begin
                    chk("stall_price_stable", ord_price, prev_price);
                    chk("stall_side_stable", ord_side, prev_side);
                end
                if (reject) rej_seen++;
                if (ord_valid && ord_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_order: got side %0d price %0d, expected none",
                                 ord_side, ord_price);
                    end else begin
                        e = exp_q.pop_front();
                        chk("order_side", ord_side, e.side);
                        chk("order_price", ord_price, e.price);
                    end
                    hs_count++;
                    hs_rel.push_back(cyc - base + 1);
                end
                prev_stall = ord_valid && !ord_ready;
                prev_price = ord_price;
                prev_side  = ord_side;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        chk_reset_vals("reset");

        // Basic buy
        ord_ready = 1'b1;
        bid_price = 8'h70;
        buy_req   = 1'b1;
        expect_ord(1'b0, 8'h70);
        tick();
        buy_req = 1'b0;
        chk("basic_n1_valid", ord_valid, 0);
        tick();
        chk("basic_n2_valid", ord_valid, 1);
        tick();
        chk("basic_done_valid", ord_valid, 0);
        chk("basic_position", position, 1);
        chk("basic_tokens", tokens, 3);
        tick(3);

        // Rate limit: buy_req held so each grant is immediately re-requested
        do_reset();
        ord_ready = 1'b1;
        hs_rel.delete();
        hs0 = hs_count;
        bid_price = 8'h55;
        buy_req   = 1'b1;
        repeat (6) expect_ord(1'b0, 8'h55);
        tick(32);
        buy_req = 1'b0;
        wait_hs(hs0 + 6);
        chk("rate_hs_n", hs_rel.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < hs_rel.size()) chk($sformatf("rate_hs_cycle%0d", i), hs_rel[i], rate_exp[i]);
        end
        chk("rate_position", position, 6);
        chk("rate_tokens", tokens, 0);
        tick(3);

        // Position limit: climb to +8, the next buy is rejected, a sell still goes
        bid_price = 8'h66;
        buy_req   = 1'b1;
        expect_ord(1'b0, 8'h66);
        tick();
        buy_req = 1'b0;
        wait_hs(hs0 + 7);
        tick(3);
        bid_price = 8'h67;
        buy_req   = 1'b1;
        expect_ord(1'b0, 8'h67);
        tick();
        buy_req = 1'b0;
        wait_hs(hs0 + 8);
        tick(3);
        chk("pos_at_limit", position, 8);
        bid_price = 8'h68;
        buy_req   = 1'b1;
        tick();
        buy_req = 1'b0;
        chk("reject_before", reject, 0);
        tick();
        chk("reject_pulse", reject, 1);
        rej_exp++;
        tick();
        chk("reject_cleared", reject, 0);
        chk("pos_held", position, 8);
        ask_price = 8'h99;
        sell_req  = 1'b1;
        expect_ord(1'b1, 8'h99);
        tick();
        sell_req = 1'b0;
        wait_hs(hs0 + 9);
        chk("pos_after_sell", position, 7);
        tick(3);

        // Backpressure with a moving bid
        do_reset();
        hs0 = hs_count;
        bid_price = 8'h20;
        buy_req   = 1'b1;
        expect_ord(1'b0, 8'h20);
        tick();
        for (int i = 0; i < 10; i++) begin
            bid_price = 8'h30 + 8'(i);
            tick();
        end
        buy_req = 1'b0;
        chk("bp_valid", ord_valid, 1);
        chk("bp_price", ord_price, 8'h20);
        expect_ord(1'b0, 8'h39);
        ord_ready = 1'b1;
        wait_hs(hs0 + 2);
        tick(3);

        // Kill during ISSUE
        do_reset();
        bid_price = 8'h41;
        ask_price = 8'hA1;
        buy_req   = 1'b1;
        sell_req  = 1'b1;
        expect_ord(1'b0, 8'h41);
        tick();
        buy_req  = 1'b0;
        sell_req = 1'b0;
        tick();
        chk("kill_issue_valid", ord_valid, 1);
        chk("kill_issue_side", ord_side, 0);
        kill = 1'b1;
        tick();
        hs0 = hs_count;
        ord_ready = 1'b1;
        tick();
        chk("kill_hs_completes", hs_count, hs0 + 1);
        kill = 1'b0;
        tick(8);
        chk("kill_sell_cleared", hs_count, hs0 + 1);
        chk("kill_position", position, 1);
        kill      = 1'b1;
        sell_req  = 1'b1;
        ask_price = 8'hB2;
        tick();
        kill     = 1'b0;
        sell_req = 1'b0;
        tick(6);
        chk("kill_same_cycle_req", hs_count, hs0 + 1);

        // Reset mid-ISSUE; last side was buy, so the tie goes to sell here
        ord_ready = 1'b0;
        bid_price = 8'h5A;
        ask_price = 8'hC3;
        buy_req   = 1'b1;
        sell_req  = 1'b1;
        tick();
        buy_req  = 1'b0;
        sell_req = 1'b0;
        tick();
        chk("rmi_valid", ord_valid, 1);
        chk("rmi_side", ord_side, 1);
        chk("rmi_price", ord_price, 8'hC3);
        reset = 1'b1;
        tick();
        chk_reset_vals("rmi");
        tick();
        reset = 1'b0;
        base  = cyc;
        hs0   = hs_count;
        ord_ready = 1'b1;
        tick(8);
        chk("rmi_nothing_pending", hs_count, hs0);

        // Tie arbitration after reset: buy first
        do_reset();
        ord_ready = 1'b1;
        bid_price = 8'h70;
        ask_price = 8'h90;
        buy_req   = 1'b1;
        sell_req  = 1'b1;
        expect_ord(1'b0, 8'h70);
        expect_ord(1'b1, 8'h90);
        tick();
        buy_req  = 1'b0;
        sell_req = 1'b0;
        tick();
        chk("tie_first_valid", ord_valid, 1);
        chk("tie_first_side", ord_side, 0);
        tick(3);
        chk("tie_cooldown_valid", ord_valid, 0);
        tick();
        chk("tie_second_valid", ord_valid, 1);
        chk("tie_second_side", ord_side, 1);
        tick();
        chk("tie_position", position, 0);
        chk("tie_tokens", tokens, 2);
        tick(4);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("reject_count", rej_seen, rej_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
